uart_rx_deser: RTL and testbench

- Receive front end of the UART peripheral.
- Oversamples the serial RX line at 16x the bit rate, detects and validates start bits, and deserializes 8-bit frames with optional parity.
- Hands each completed byte, with its error flags, to the RX FIFO write port inside the UART_wb register block.
- Sits directly between the RX pad and the RX FIFO.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_deser_if.sv | 20 ++
 rtl/uart_baud_tick.sv | 38 +++
 rtl/uart_rx_deser.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_deser.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Types and constants shared by the UART receive and transmit datapaths.
package uart_pkg;

  localparam int OVS_DEF   = 16;
  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HI
  } rx_state_t;

  typedef struct packed {
    logic par;
    logic frm;
    logic brk;
    logic ovr;
  } rx_err_t;

endpackage

// File: rtl/uart_rx_deser_if.sv
// RX FIFO write-side bundle: byte, strobe, error pulses and the FIFO full back-pressure.
interface uart_rx_deser_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       par_err;
  logic       frm_err;
  logic       brk;
  logic       ovr_err;
  logic       rx_full;

  modport master (
    output rx_data, rx_valid, par_err, frm_err, brk, ovr_err,
    input  rx_full
  );

  modport slave (
    input  rx_data, rx_valid, par_err, frm_err, brk, ovr_err,
    output rx_full
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Baud divisor counter: one-cycle tick every divisor_i clocks; a new divisor is
// picked up at the next wrap, and a zero divisor stops the ticks.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [DIV_W-1:0] divisor_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  always_comb begin
    wrap  = (div_q != '0) && (cnt_q == div_q - DIV_W'(1));
    div_d = div_q;
    cnt_d = cnt_q + DIV_W'(1);
    if (div_q == '0 || wrap) begin
      div_d = divisor_i;
      cnt_d = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = wrap;

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive front end: 16x oversampled start detection and 8N1/8P1 deserialization
// into the RX FIFO. Build option: define UART_RX_MAJORITY_EN for 2-of-3 bit voting.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int OVS   = OVS_DEF,
  parameter int DIV_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             RX,
  input  logic [DIV_W-1:0] divisor,
  input  logic             par_en,
  input  logic             par_odd,
  output logic             busy,
  uart_rx_deser_if.master  fifo
);

  localparam int SC_W = $clog2(OVS);
  localparam int BC_W = $clog2(DATA_BITS);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [SC_W-1:0] START_DEC = SC_W'(OVS / 2);
`else
  localparam logic [SC_W-1:0] START_DEC = SC_W'(OVS / 2 - 1);
`endif
  localparam logic [SC_W-1:0] BIT_DEC = SC_W'(OVS - 1);

  rx_state_t            state_q, state_d;
  logic                 rx_s1_q, rxs_q, rx_prev_q, armed_q;
  logic [1:0]           fresh_q;
  logic [SC_W-1:0]      scnt_q, scnt_d, dec_pt;
  logic [BC_W-1:0]      bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d, rx_data_q, rx_data_d;
  logic                 pen_q, pen_d, podd_q, podd_d, perr_q, perr_d;
  logic                 vld_q, vld_d;
  rx_err_t              err_q, err_d;
  logic                 tick, start_edge, bitv, dec_hit, done, stop_bit;

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .Clk       (Clk),
    .Rst       (Rst),
    .divisor_i (divisor),
    .tick_o    (tick)
  );

  // Edge detection is armed only after a genuine high has passed the synchronizer.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rx_s1_q   <= 1'b1;
      rxs_q     <= 1'b1;
      rx_prev_q <= 1'b1;
      fresh_q   <= '0;
      armed_q   <= 1'b0;
    end else begin
      rx_s1_q   <= RX;
      rxs_q     <= rx_s1_q;
      rx_prev_q <= rxs_q;
      fresh_q   <= {fresh_q[0], 1'b1};
      armed_q   <= armed_q | (fresh_q[1] & rxs_q);
    end
  end

  assign start_edge = armed_q & rx_prev_q & ~rxs_q & (divisor != '0);
  assign dec_pt     = (state_q == START) ? START_DEC : BIT_DEC;

`ifdef UART_RX_MAJORITY_EN
  logic smp_a_q, smp_b_q;

  always_ff @(posedge Clk) begin
    if (tick && scnt_q == dec_pt - SC_W'(2)) smp_a_q <= rxs_q;
    if (tick && scnt_q == dec_pt - SC_W'(1)) smp_b_q <= rxs_q;
  end

  assign bitv = (smp_a_q & smp_b_q) | (smp_a_q & rxs_q) | (smp_b_q & rxs_q);
`else
  assign bitv = rxs_q;
`endif

  always_comb begin
    state_d  = state_q;
    scnt_d   = scnt_q;
    bcnt_d   = bcnt_q;
    shreg_d  = shreg_q;
    pen_d    = pen_q;
    podd_d   = podd_q;
    perr_d   = perr_q;
    done     = 1'b0;
    stop_bit = 1'b1;
    dec_hit  = tick && (scnt_q == dec_pt);
    if (tick) scnt_d = scnt_q + SC_W'(1);
    unique case (state_q)
      IDLE: if (start_edge) begin
        scnt_d  = '0;
        bcnt_d  = '0;
        pen_d   = par_en;
        podd_d  = par_odd;
        perr_d  = 1'b0;
        state_d = START;
      end
      START: if (dec_hit) begin
        scnt_d  = '0;
        state_d = bitv ? IDLE : DATA;
      end
      DATA: if (dec_hit) begin
        scnt_d  = '0;
        shreg_d = {bitv, shreg_q[DATA_BITS-1:1]};
        bcnt_d  = bcnt_q + BC_W'(1);
        if (bcnt_q == BC_W'(DATA_BITS - 1)) state_d = pen_q ? PARITY : STOP;
      end
      PARITY: if (dec_hit) begin
        scnt_d  = '0;
        perr_d  = ((^shreg_q) ^ bitv) != podd_q;
        state_d = STOP;
      end
      STOP: if (dec_hit) begin
        scnt_d   = '0;
        done     = 1'b1;
        stop_bit = bitv;
        state_d  = bitv ? IDLE : WAIT_HI;
      end
      WAIT_HI: if (rxs_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    vld_d      = done & ~fifo.rx_full;
    rx_data_d  = vld_d ? shreg_q : rx_data_q;
    err_d.par  = done & perr_q;
    err_d.frm  = done & ~stop_bit;
    err_d.brk  = done & ~stop_bit & (shreg_q == '0);
    err_d.ovr  = done & fifo.rx_full;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      scnt_q    <= '0;
      bcnt_q    <= '0;
      vld_q     <= 1'b0;
      err_q     <= '0;
      rx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      scnt_q    <= scnt_d;
      bcnt_q    <= bcnt_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
      rx_data_q <= rx_data_d;
    end
  end

  always_ff @(posedge Clk) begin
    shreg_q <= shreg_d;
    pen_q   <= pen_d;
    podd_q  <= podd_d;
    perr_q  <= perr_d;
  end

  assign fifo.rx_valid = vld_q;
  assign fifo.rx_data  = rx_data_q;
  assign fifo.par_err  = err_q.par;
  assign fifo.frm_err  = err_q.frm;
  assign fifo.brk      = err_q.brk;
  assign fifo.ovr_err  = err_q.ovr;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: serial frames at divisor 4 with a scoreboard of
// expected FIFO-side events.
module tb_uart_rx_deser;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic       p;
    logic       f;
    logic       b;
    logic       o;
  } ev_t;

  localparam int BIT = 64;

  logic        Clk     = 1'b0;
  logic        Rst     = 1'b1;
  logic        RX      = 1'b1;
  logic        par_en  = 1'b0;
  logic        par_odd = 1'b0;
  logic [15:0] divisor = 16'd4;
  logic        busy;

  uart_rx_deser_if bus ();

  ev_t        sb[$];
  int         vecs = 0;
  int         miscompares = 0;
  int         brk_cnt = 0;
  int         vld_cnt = 0;
  logic [7:0] last_data = 8'h00;

  uart_rx_deser #(.OVS(16), .DIV_W(16)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .RX      (RX),
    .divisor (divisor),
    .par_en  (par_en),
    .par_odd (par_odd),
    .busy    (busy),
    .fifo    (bus)
  );

  always #5 Clk = ~Clk;

  // Every output event is matched against the oldest expected one.
  always @(negedge Clk) begin
    ev_t obs_e;
    ev_t exp_e;
    if (!Rst && (bus.rx_valid || bus.par_err || bus.frm_err || bus.brk || bus.ovr_err)) begin
      obs_e = {bus.rx_valid, bus.rx_data, bus.par_err, bus.frm_err, bus.brk, bus.ovr_err};
      if (bus.brk) brk_cnt++;
      if (bus.rx_valid) vld_cnt++;
      vecs++;
      assert (sb.size() != 0)
      else begin
        miscompares++;
        $error("FAIL unexpected_event obs=%h exp=none", obs_e);
      end
      if (sb.size() != 0) begin
        exp_e = sb.pop_front();
        vecs++;
        assert (obs_e === exp_e)
        else begin
          miscompares++;
          $error("FAIL event obs=%h exp=%h", obs_e, exp_e);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vecs++;
    assert (obs === exp_v)
    else begin
      miscompares++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic b);
    RX = b;
    repeat (BIT) @(negedge Clk);
  endtask

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n * BIT) @(negedge Clk);
  endtask

  task automatic send(input logic [7:0] d, input logic pbit, input logic stop, input logic full);
    ev_t e;
    e.v = !full;
    e.d = full ? last_data : d;
    e.p = par_en && (((^d) ^ pbit) != par_odd);
    e.f = !stop;
    e.b = !stop && (d == 8'h00);
    e.o = full;
    sb.push_back(e);
    if (!full) last_data = d;
    bus.rx_full = full;
    drive(1'b0);
    for (int i = 0; i < 8; i++) drive(d[i]);
    if (par_en) drive(pbit);
    drive(stop);
    bus.rx_full = 1'b0;
  endtask

  initial begin
    ev_t e;
    int  b0;
    int  v0;
    bus.rx_full = 1'b0;
    repeat (5) @(negedge Clk);
    chk("reset_outs", {bus.rx_data, bus.rx_valid, bus.par_err, bus.frm_err, bus.brk, bus.ovr_err, busy}, 0);
    Rst = 1'b0;
    repeat (10) @(negedge Clk);
    chk("idle_outs", {bus.rx_data, bus.rx_valid, bus.par_err, bus.frm_err, bus.brk, bus.ovr_err, busy}, 0);

    par_en  = 1'b1;
    par_odd = 1'b1;
    send(8'hA5, 1'b1, 1'b1, 1'b0);
    idle(1);
    chk("a5_good_drain", sb.size(), 0);
    chk("a5_good_data", bus.rx_data, 8'hA5);

    send(8'hA5, 1'b0, 1'b1, 1'b0);
    idle(1);
    chk("a5_parerr_drain", sb.size(), 0);

    send(8'h55, 1'b1, 1'b1, 1'b1);
    idle(1);
    chk("ovr_drain", sb.size(), 0);
    chk("ovr_data_kept", bus.rx_data, 8'hA5);

    par_en = 1'b0;
    send(8'h3C, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("frm_drain", sb.size(), 0);

    e = {1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    sb.push_back(e);
    last_data = 8'h00;
    b0 = brk_cnt;
    v0 = vld_cnt;
    RX = 1'b0;
    repeat (30 * BIT) @(negedge Clk);
    chk("brk_once", brk_cnt - b0, 1);
    chk("brk_valid_once", vld_cnt - v0, 1);
    chk("brk_wait_busy", busy, 1);
    idle(2);
    chk("brk_drain", sb.size(), 0);
    chk("brk_idle", busy, 0);

    v0 = vld_cnt;
    RX = 1'b0;
    repeat (12) @(negedge Clk);
    chk("glitch_busy_hi", busy, 1);
    RX = 1'b1;
    repeat (BIT) @(negedge Clk);
    chk("glitch_busy_lo", busy, 0);
    chk("glitch_no_valid", vld_cnt - v0, 0);

    divisor = 16'd0;
    repeat (10) @(negedge Clk);
    RX = 1'b0;
    repeat (20) @(negedge Clk);
    chk("div0_idle", busy, 0);
    RX = 1'b1;
    repeat (10) @(negedge Clk);
    divisor = 16'd4;
    idle(1);

    v0 = vld_cnt;
    send(8'h01, 1'b0, 1'b1, 1'b0);
    send(8'h80, 1'b0, 1'b1, 1'b0);
    idle(1);
    chk("b2b_drain", sb.size(), 0);
    chk("b2b_count", vld_cnt - v0, 2);
    chk("b2b_last", bus.rx_data, 8'h80);

    drive(1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1);
    Rst = 1'b1;
    RX  = 1'b1;
    repeat (3) @(negedge Clk);
    chk("midrst_outs", {bus.rx_data, bus.rx_valid, bus.par_err, bus.frm_err, bus.brk, bus.ovr_err, busy}, 0);
    Rst = 1'b0;
    last_data = 8'h00;
    idle(2);
    chk("postrst_outs", {bus.rx_data, bus.rx_valid, bus.par_err, bus.frm_err, bus.brk, bus.ovr_err, busy}, 0);
    send(8'h5A, 1'b0, 1'b1, 1'b0);
    idle(1);
    chk("postrst_drain", sb.size(), 0);
    chk("postrst_data", bus.rx_data, 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
